id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded control, operand data, immediate, funct and register indices from ID.
- Presents them to EX, where EX_Rs1/EX_Rs2 feed the forwarding unit and the ALU operand muxes.
- Supports a global freeze (stall), bubble insertion for load-use hazards, and flush for taken branches.

---
 rtl/id_ex_pipe_reg.sv | 161 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage RISC-V core.
// It registers the decoded control, operands, immediate, funct and register
// indices from ID and presents them to EX.
// Priority on each edge is stall (hold) > bubble/flush (NOP) > load from ID.
// A NOP clears every field, including the register indices. Because of this,
// a bubble never matches a forwarding comparison.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN. When it is defined, a
// wrapping counter of inserted NOP cycles drives bubble_cnt_o. Otherwise the
// output is tied to zero.
module id_ex_pipe_reg #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               bubble_i,
   input  logic               flush_i,
   input  logic               ID_valid_i,
   input  logic               ID_RegWrite_i,
   input  logic               ID_MemtoReg_i,
   input  logic               ID_MemRead_i,
   input  logic               ID_MemWrite_i,
   input  logic               ID_ALUSrc_i,
   input  logic [1:0]         ID_ALUOp_i,
   input  logic [DATA_W-1:0]  ID_RS1data_i,
   input  logic [DATA_W-1:0]  ID_RS2data_i,
   input  logic [DATA_W-1:0]  ID_Imm_i,
   input  logic [9:0]         ID_funct_i,
   input  logic [RADDR_W-1:0] ID_Rs1_i,
   input  logic [RADDR_W-1:0] ID_Rs2_i,
   input  logic [RADDR_W-1:0] ID_Rd_i,
   output logic               EX_valid_o,
   output logic               EX_RegWrite_o,
   output logic               EX_MemtoReg_o,
   output logic               EX_MemRead_o,
   output logic               EX_MemWrite_o,
   output logic               EX_ALUSrc_o,
   output logic [1:0]         EX_ALUOp_o,
   output logic [DATA_W-1:0]  EX_RS1data_o,
   output logic [DATA_W-1:0]  EX_RS2data_o,
   output logic [DATA_W-1:0]  EX_Imm_o,
   output logic [9:0]         EX_funct_o,
   output logic [RADDR_W-1:0] EX_Rs1_o,
   output logic [RADDR_W-1:0] EX_Rs2_o,
   output logic [RADDR_W-1:0] EX_Rd_o,
   output logic [CNT_W-1:0]   bubble_cnt_o
);

   typedef struct packed {
      logic               valid;
      logic               regwrite;
      logic               memtoreg;
      logic               memread;
      logic               memwrite;
      logic               alusrc;
      logic [1:0]         aluop;
      logic [DATA_W-1:0]  rs1data;
      logic [DATA_W-1:0]  rs2data;
      logic [DATA_W-1:0]  imm;
      logic [9:0]         funct;
      logic [RADDR_W-1:0] rs1;
      logic [RADDR_W-1:0] rs2;
      logic [RADDR_W-1:0] rd;
   } stage_t;

   stage_t id_s;
   stage_t stage_d;
   stage_t stage_q;
   logic   nop_s;

   // A NOP is inserted for a load-use bubble or a taken-branch flush, unless frozen
   assign nop_s = ~stall_i & (bubble_i | flush_i);

   // Gather the ID-side fields into one record
   always_comb begin
      id_s          = '0;
      id_s.valid    = ID_valid_i;
      id_s.regwrite = ID_RegWrite_i;
      id_s.memtoreg = ID_MemtoReg_i;
      id_s.memread  = ID_MemRead_i;
      id_s.memwrite = ID_MemWrite_i;
      id_s.alusrc   = ID_ALUSrc_i;
      id_s.aluop    = ID_ALUOp_i;
      id_s.rs1data  = ID_RS1data_i;
      id_s.rs2data  = ID_RS2data_i;
      id_s.imm      = ID_Imm_i;
      id_s.funct    = ID_funct_i;
      id_s.rs1      = ID_Rs1_i;
      id_s.rs2      = ID_Rs2_i;
      id_s.rd       = ID_Rd_i;
   end

   // Next stage contents: hold on stall, all-zero NOP on bubble/flush, else load ID
   always_comb begin
      stage_d = stage_q;
      if (stall_i) begin
         stage_d = stage_q;
      end else if (bubble_i | flush_i) begin
         stage_d = '0;
      end else begin
         stage_d = id_s;
      end
   end

   // Stage register with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign EX_valid_o    = stage_q.valid;
   assign EX_RegWrite_o = stage_q.regwrite;
   assign EX_MemtoReg_o = stage_q.memtoreg;
   assign EX_MemRead_o  = stage_q.memread;
   assign EX_MemWrite_o = stage_q.memwrite;
   assign EX_ALUSrc_o   = stage_q.alusrc;
   assign EX_ALUOp_o    = stage_q.aluop;
   assign EX_RS1data_o  = stage_q.rs1data;
   assign EX_RS2data_o  = stage_q.rs2data;
   assign EX_Imm_o      = stage_q.imm;
   assign EX_funct_o    = stage_q.funct;
   assign EX_Rs1_o      = stage_q.rs1;
   assign EX_Rs2_o      = stage_q.rs2;
   assign EX_Rd_o       = stage_q.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q;

   // Count each inserted NOP once; bubble and flush together still count once
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (nop_s) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   // Bubble counter register, wraps naturally modulo 2^CNT_W
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`else
   logic unused_nop_s;
   assign unused_nop_s = nop_s;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (CNT_W set to 4 to exercise wrap).
module tb_id_ex_pipe_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   typedef struct packed {
      logic          valid;
      logic          regwrite;
      logic          memtoreg;
      logic          memread;
      logic          memwrite;
      logic          alusrc;
      logic [1:0]    aluop;
      logic [DW-1:0] rs1data;
      logic [DW-1:0] rs2data;
      logic [DW-1:0] imm;
      logic [9:0]    funct;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
   } pipe_t;

   typedef struct {
      logic          stall;
      logic          bubble;
      logic          flush;
      pipe_t         id;
      pipe_t         exp_p;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   typedef struct {
      pipe_t         p;
      logic [CW-1:0] cnt;
      string         name;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          bubble = 1'b0;
   logic          flush = 1'b0;
   pipe_t         id_s = '0;
   pipe_t         ex_s;
   logic          ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc;
   logic [1:0]    ex_aluop;
   logic [DW-1:0] ex_rs1data, ex_rs2data, ex_imm;
   logic [9:0]    ex_funct;
   logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [CW-1:0] cnt_s;

   int    checks = 0;
   int    failures = 0;
   pipe_t m_p = '0;
   logic [CW-1:0] m_cnt = '0;
   sb_t   exp_q[$];
   vec_t  vecs[$];

   id_ex_pipe_reg #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble), .flush_i(flush),
      .ID_valid_i(id_s.valid), .ID_RegWrite_i(id_s.regwrite), .ID_MemtoReg_i(id_s.memtoreg),
      .ID_MemRead_i(id_s.memread), .ID_MemWrite_i(id_s.memwrite), .ID_ALUSrc_i(id_s.alusrc),
      .ID_ALUOp_i(id_s.aluop), .ID_RS1data_i(id_s.rs1data), .ID_RS2data_i(id_s.rs2data),
      .ID_Imm_i(id_s.imm), .ID_funct_i(id_s.funct), .ID_Rs1_i(id_s.rs1),
      .ID_Rs2_i(id_s.rs2), .ID_Rd_i(id_s.rd),
      .EX_valid_o(ex_valid), .EX_RegWrite_o(ex_regwrite), .EX_MemtoReg_o(ex_memtoreg),
      .EX_MemRead_o(ex_memread), .EX_MemWrite_o(ex_memwrite), .EX_ALUSrc_o(ex_alusrc),
      .EX_ALUOp_o(ex_aluop), .EX_RS1data_o(ex_rs1data), .EX_RS2data_o(ex_rs2data),
      .EX_Imm_o(ex_imm), .EX_funct_o(ex_funct), .EX_Rs1_o(ex_rs1),
      .EX_Rs2_o(ex_rs2), .EX_Rd_o(ex_rd), .bubble_cnt_o(cnt_s)
   );

   assign ex_s = {ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc,
                  ex_aluop, ex_rs1data, ex_rs2data, ex_imm, ex_funct, ex_rs1, ex_rs2, ex_rd};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_pipe(input string name, input pipe_t act, input pipe_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s_cnt: got %0d required %0d", name, act, exp);
      end
   endtask

   // Reference behaviour of one clock edge
   task automatic model_step(input logic s, input logic b, input logic f, input pipe_t d);
      if (!s) begin
         if (b || f) begin
            m_p = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
            m_cnt = m_cnt + 4'd1;
`endif
         end else begin
            m_p = d;
         end
      end
   endtask

   // Drive one edge, push the expectation, then pop and compare after the edge
   task automatic drive_edge(input logic s, input logic b, input logic f, input pipe_t d, input string name);
      sb_t e;
      stall = s; bubble = b; flush = f; id_s = d;
      model_step(s, b, f, d);
      exp_q.push_back('{p: m_p, cnt: m_cnt, name: name});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s: scoreboard empty, got output with no expectation", name);
      end else begin
         e = exp_q.pop_front();
         chk_pipe(e.name, ex_s, e.p);
         chk_cnt(e.name, cnt_s, e.cnt);
      end
   endtask

   function automatic pipe_t mk(input int k);
      pipe_t p;
      p.valid    = 1'b1;
      p.regwrite = k[0];
      p.memtoreg = k[1];
      p.memread  = k[1];
      p.memwrite = k[2];
      p.alusrc   = k[3];
      p.aluop    = 2'(k);
      p.rs1data  = 32'hA5A50000 ^ 32'(k * 32'h01010101);
      p.rs2data  = 32'h0F0F1234 + 32'(k);
      p.imm      = 32'hFFFFF000 | 32'(k);
      p.funct    = 10'(k * 37);
      p.rs1      = 5'(k + 1);
      p.rs2      = 5'(k + 2);
      p.rd       = 5'(k + 3);
      return p;
   endfunction

   initial begin
      pipe_t d;
      pipe_t zero_p;
      logic [CW-1:0] cnt_before;
      zero_p = '0;

      // Reset held from time 0: everything must read zero
      #2;
      chk_pipe("reset_init", ex_s, zero_p);
      chk_cnt("reset_init", cnt_s, 4'd0);
      @(posedge clk); #3;
      rst = 1'b0;

      // Load nonzero, then assert reset between edges
      d = '1;
      drive_edge(1'b0, 1'b0, 1'b0, d, "load_all_ones");
      #2 rst = 1'b1;
      #1;
      chk_pipe("async_reset", ex_s, zero_p);
      chk_cnt("async_reset", cnt_s, 4'd0);
      m_p = '0; m_cnt = '0;
      @(posedge clk); #1;
      chk_pipe("reset_held", ex_s, zero_p);
      #2 rst = 1'b0;
      @(negedge clk);
      d = '0; d.rd = 5'd5; d.regwrite = 1'b1; d.valid = 1'b1;
      drive_edge(1'b0, 1'b0, 1'b0, d, "after_reset");
      checks++;
      if (ex_rd !== 5'd5 || ex_regwrite !== 1'b1) begin
         failures++;
         $display("FAIL after_reset_rd: got rd=%0d rw=%0b required rd=5 rw=1", ex_rd, ex_regwrite);
      end

      // Pass-through
      d = '0; d.valid = 1'b1; d.rs1data = 32'h12345678; d.imm = 32'hFFFFF800;
      d.rs1 = 5'd3; d.aluop = 2'b10;
      drive_edge(1'b0, 1'b0, 1'b0, d, "pass_through");
      checks++;
      if (ex_rs1data !== 32'h12345678 || ex_imm !== 32'hFFFFF800 || ex_rs1 !== 5'd3 ||
          ex_aluop !== 2'b10 || ex_valid !== 1'b1) begin
         failures++;
         $display("FAIL pass_fields: got rs1data=%h imm=%h rs1=%0d aluop=%b v=%b", ex_rs1data, ex_imm, ex_rs1, ex_aluop, ex_valid);
      end

      // Stall holds for three edges, then the new value lands
      d = '0; d.valid = 1'b1; d.rd = 5'd7;
      drive_edge(1'b0, 1'b0, 1'b0, d, "stall_load7");
      d.rd = 5'd9;
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1, 1'b0, 1'b0, d, "stall_hold");
         checks++;
         if (ex_rd !== 5'd7) begin
            failures++;
            $display("FAIL stall_rd: got %0d required 7", ex_rd);
         end
      end
      drive_edge(1'b0, 1'b0, 1'b0, d, "stall_release");
      checks++;
      if (ex_rd !== 5'd9) begin
         failures++;
         $display("FAIL stall_release_rd: got %0d required 9", ex_rd);
      end

      // Load-use bubble after lw x5
      d = '0; d.valid = 1'b1; d.memread = 1'b1; d.memtoreg = 1'b1; d.regwrite = 1'b1;
      d.alusrc = 1'b1; d.rd = 5'd5; d.rs1 = 5'd2; d.imm = 32'd8;
      drive_edge(1'b0, 1'b0, 1'b0, d, "lw_x5");
      drive_edge(1'b0, 1'b1, 1'b0, mk(4), "load_use_bubble");
      chk_pipe("bubble_is_nop", ex_s, zero_p);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk_cnt("bubble_first", cnt_s, 4'd1);
`else
      chk_cnt("bubble_first", cnt_s, 4'd0);
`endif

      // Stall with flush holds; bubble with flush counts once
      drive_edge(1'b0, 1'b0, 1'b0, mk(6), "pre_simul");
      cnt_before = m_cnt;
      drive_edge(1'b1, 1'b0, 1'b1, mk(7), "stall_flush_hold");
      chk_pipe("stall_flush_value", ex_s, mk(6));
      drive_edge(1'b0, 1'b1, 1'b1, mk(8), "bubble_flush_once");
`ifdef ID_EX_BUBBLE_CNT_EN
      chk_cnt("bubble_flush_delta", cnt_s, cnt_before + 4'd1);
`else
      chk_cnt("bubble_flush_delta", cnt_s, 4'd0);
`endif

      // Table-driven vectors; expectations precomputed from the reference model
      for (int k = 0; k < 14; k++) begin
         vec_t v;
         v.stall  = (k % 5 == 2);
         v.bubble = (k % 4 == 3);
         v.flush  = (k % 6 == 1);
         v.id     = mk(k + 10);
         if (k % 7 == 0) v.id.valid = 1'b0;
         model_step(v.stall, v.bubble, v.flush, v.id);
         v.exp_p   = m_p;
         v.exp_cnt = m_cnt;
         vecs.push_back(v);
      end
      m_p = vecs[0].stall ? m_p : m_p;
      // Rewind model to the DUT's current state before applying the table
      m_p = mk(0); m_p = '0;
      m_cnt = cnt_s;
      for (int k = 0; k < vecs.size(); k++) begin
         stall = vecs[k].stall; bubble = vecs[k].bubble; flush = vecs[k].flush; id_s = vecs[k].id;
         exp_q.push_back('{p: vecs[k].exp_p, cnt: vecs[k].exp_cnt, name: $sformatf("vec%0d", k)});
         @(posedge clk); #1;
         begin
            sb_t e;
            e = exp_q.pop_front();
            chk_pipe(e.name, ex_s, e.p);
            chk_cnt(e.name, cnt_s, e.cnt);
         end
      end
      m_p = vecs[vecs.size()-1].exp_p;
      m_cnt = vecs[vecs.size()-1].exp_cnt;

      // Sixteen consecutive bubbles: 4-bit counter returns to its start value
      cnt_before = m_cnt;
      for (int i = 0; i < 16; i++) begin
         drive_edge(1'b0, 1'b1, 1'b0, mk(i + 30), "wrap_bubble");
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      chk_cnt("wrap_full", cnt_s, cnt_before);
`else
      chk_cnt("wrap_full", cnt_s, 4'd0);
`endif
      drive_edge(1'b0, 1'b0, 1'b0, mk(50), "after_wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
